// File: rtl/alu_arbiter_if.sv
// Bus bundle between the two requesters, the shared ALU and the response
// consumer. The slave modport is the arbiter's view; the master modport is
// the view of everything around it (requesters, ALU, consumer).
//
// Handshake rule for both the request and the response channels: a transfer
// happens on a rising clock edge where valid and ready are both high. Once
// valid is raised, the producer holds valid and payload stable until that
// transfer happens. Ready may depend combinationally on valid.
interface alu_arbiter_if #(
   parameter int WIDTH = 32
);
   // Requester 0
   logic             req0_valid_i;
   logic             req0_ready_o;
   logic [WIDTH-1:0] req0_data1_i;
   logic [WIDTH-1:0] req0_data2_i;
   logic [2:0]       req0_action_i;

   // Requester 1
   logic             req1_valid_i;
   logic             req1_ready_o;
   logic [WIDTH-1:0] req1_data1_i;
   logic [WIDTH-1:0] req1_data2_i;
   logic [2:0]       req1_action_i;

   // Shared combinational ALU
   logic [WIDTH-1:0] alu_data1_o;
   logic [WIDTH-1:0] alu_data2_o;
   logic [2:0]       alu_action_o;
   logic [WIDTH-1:0] alu_result_i;

   // Response channel
   logic             rsp_valid_o;
   logic             rsp_ready_i;
   logic             rsp_id_o;
   logic [WIDTH-1:0] rsp_result_o;

   modport slave (
      input  req0_valid_i, req0_data1_i, req0_data2_i, req0_action_i,
      output req0_ready_o,
      input  req1_valid_i, req1_data1_i, req1_data2_i, req1_action_i,
      output req1_ready_o,
      output alu_data1_o, alu_data2_o, alu_action_o,
      input  alu_result_i,
      output rsp_valid_o, rsp_id_o, rsp_result_o,
      input  rsp_ready_i
   );

   modport master (
      output req0_valid_i, req0_data1_i, req0_data2_i, req0_action_i,
      input  req0_ready_o,
      output req1_valid_i, req1_data1_i, req1_data2_i, req1_action_i,
      input  req1_ready_o,
      input  alu_data1_o, alu_data2_o, alu_action_o,
      output alu_result_i,
      input  rsp_valid_o, rsp_id_o, rsp_result_o,
      output rsp_ready_i
   );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a single shared combinational ALU.
// One operation is in flight at a time: IDLE grants and registers a request,
// EXEC drives the ALU from registered operands for a fixed number of cycles,
// RESP holds the captured result until the consumer takes it.
//
// Timing from an accept at edge T: the first EXEC cycle lets the registered
// operands settle through the ALU, then the cycle counter runs down to zero
// and the result is captured. Non-MUL responses appear after edge T+2, MUL
// responses after edge T+1+MUL_LAT.
module alu_arbiter #(
   parameter int WIDTH   = 32,
   parameter int MUL_LAT = 3   // legal range 1..15
) (
   input  logic         clk_i,
   input  logic         rst_i,    // asynchronous, active-low
   alu_arbiter_if.slave bus,
   output logic [1:0]   state_o   // FSM state for observation
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [2:0] ACT_MUL  = 3'b100;
   localparam logic [3:0] MUL_LOAD = 4'(MUL_LAT - 1);

   state_t           state;
   logic             ptr;        // round-robin preference: requester to favour
   logic [3:0]       count;      // remaining EXEC cycles before capture
   logic             settle;     // first EXEC cycle after an accept
   logic             op_id;      // owner of the operation in flight
   logic [WIDTH-1:0] alu_d1_q;
   logic [WIDTH-1:0] alu_d2_q;
   logic [2:0]       alu_act_q;
   logic             rsp_valid_q;
   logic             rsp_id_q;
   logic [WIDTH-1:0] rsp_result_q;

   logic             grant0;
   logic             grant1;
   logic             accept;
   logic [WIDTH-1:0] acc_d1;
   logic [WIDTH-1:0] acc_d2;
   logic [2:0]       acc_act;

   // Grant: the favoured requester wins if valid, otherwise the other one.
   // Gated with reset so ready stays low while reset is held.
   assign grant0 = rst_i && (state == IDLE) && bus.req0_valid_i &&
                   (!ptr || !bus.req1_valid_i);
   assign grant1 = rst_i && (state == IDLE) && bus.req1_valid_i &&
                   ( ptr || !bus.req0_valid_i);
   assign accept = grant0 || grant1;

   // Payload of the granted requester
   assign acc_d1  = grant1 ? bus.req1_data1_i  : bus.req0_data1_i;
   assign acc_d2  = grant1 ? bus.req1_data2_i  : bus.req0_data2_i;
   assign acc_act = grant1 ? bus.req1_action_i : bus.req0_action_i;

   assign bus.req0_ready_o = grant0;
   assign bus.req1_ready_o = grant1;

   assign bus.alu_data1_o  = alu_d1_q;
   assign bus.alu_data2_o  = alu_d2_q;
   assign bus.alu_action_o = alu_act_q;

   assign bus.rsp_valid_o  = rsp_valid_q;
   assign bus.rsp_id_o     = rsp_id_q;
   assign bus.rsp_result_o = rsp_result_q;

   assign state_o = state;

   // Main FSM: accept in IDLE, count down in EXEC, hold the response in RESP.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state        <= IDLE;
         ptr          <= 1'b0;
         count        <= 4'd0;
         settle       <= 1'b0;
         op_id        <= 1'b0;
         alu_d1_q     <= '0;
         alu_d2_q     <= '0;
         alu_act_q    <= 3'b000;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= 1'b0;
         rsp_result_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  // Operands and action go straight to the ALU registers and
                  // stay there until the next accept.
                  alu_d1_q  <= acc_d1;
                  alu_d2_q  <= acc_d2;
                  alu_act_q <= acc_act;
                  op_id     <= grant1;
                  count     <= (acc_act == ACT_MUL) ? MUL_LOAD : 4'd0;
                  settle    <= 1'b1;
                  state     <= EXEC;
               end
            end

            EXEC: begin
               if (settle) begin
                  settle <= 1'b0;
               end else if (count == 4'd0) begin
                  // ALU output is passed through untouched.
                  rsp_result_q <= bus.alu_result_i;
                  rsp_id_q     <= op_id;
                  rsp_valid_q  <= 1'b1;
                  state        <= RESP;
               end else begin
                  count <= count - 4'd1;
               end
            end

            RESP: begin
               if (bus.rsp_ready_i) begin
                  // Next time, favour the requester that was not just served.
                  rsp_valid_q <= 1'b0;
                  ptr         <= ~rsp_id_q;
                  state       <= IDLE;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios followed by a randomized phase,
// all checked against a transaction-level reference model.
module tb_alu_arbiter;

   localparam int W       = 32;
   localparam int MUL_LAT = 3;

   localparam logic [2:0] A_AND = 3'b000;
   localparam logic [2:0] A_OR  = 3'b001;
   localparam logic [2:0] A_ADD = 3'b010;
   localparam logic [2:0] A_SUB = 3'b011;
   localparam logic [2:0] A_MUL = 3'b100;
   localparam logic [2:0] A_ILL = 3'b111;

   // ---------------- clock / reset ----------------
   logic clk_i = 1'b0;
   logic rst_i = 1'b0;
   always #5 clk_i = ~clk_i;

   alu_arbiter_if #(.WIDTH(W)) bus ();
   logic [1:0] state_o;

   alu_arbiter #(.WIDTH(W), .MUL_LAT(MUL_LAT)) dut (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .bus     (bus),
      .state_o (state_o)
   );

   // ---------------- shared ALU stand-in ----------------
   logic [W-1:0] illegal_val = 32'hFFFF_FFFF;

   always_comb begin
      case (bus.alu_action_o)
         A_AND:   bus.alu_result_i = bus.alu_data1_o & bus.alu_data2_o;
         A_OR:    bus.alu_result_i = bus.alu_data1_o | bus.alu_data2_o;
         A_ADD:   bus.alu_result_i = bus.alu_data1_o + bus.alu_data2_o;
         A_SUB:   bus.alu_result_i = bus.alu_data1_o - bus.alu_data2_o;
         A_MUL:   bus.alu_result_i = bus.alu_data1_o * bus.alu_data2_o;
         default: bus.alu_result_i = illegal_val;
      endcase
   end

   // ---------------- checking ----------------
   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_ready0"}, 64'(bus.req0_ready_o), 64'd0);
      chk({tag, "_ready1"}, 64'(bus.req1_ready_o), 64'd0);
      chk({tag, "_rsp_valid"}, 64'(bus.rsp_valid_o), 64'd0);
      chk({tag, "_rsp_id"}, 64'(bus.rsp_id_o), 64'd0);
      chk({tag, "_rsp_result"}, 64'(bus.rsp_result_o), 64'd0);
      chk({tag, "_alu_d1"}, 64'(bus.alu_data1_o), 64'd0);
      chk({tag, "_alu_d2"}, 64'(bus.alu_data2_o), 64'd0);
      chk({tag, "_alu_act"}, 64'(bus.alu_action_o), 64'd0);
   endtask

   // ---------------- reference model ----------------
   // One transaction at a time: "busy" counts down the response latency,
   // "resp" means a response is waiting for the consumer. Expected results
   // come from the operation's definition, queued at accept time.
   bit           m_busy, m_resp, m_ptr;
   int           m_wait;
   logic [W-1:0] m_a1, m_a2;
   logic [2:0]   m_act;
   logic [W-1:0] exp_q[$];
   bit           id_q[$];
   bit           acc_flag[2];
   int           dut_grants[$];

   function automatic logic [W-1:0] golden(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [2:0] act);
      case (act)
         A_AND:   return a & b;
         A_OR:    return a | b;
         A_ADD:   return a + b;
         A_SUB:   return a - b;
         A_MUL:   return W'(a * b);
         default: return illegal_val;
      endcase
   endfunction

   // Inputs change just after rising edges, so the falling edge sees exactly
   // what the next rising edge will sample: check outputs, then advance.
   always @(negedge clk_i) begin
      logic e_r0, e_r1;
      if (!rst_i) begin
         check_zero("reset");
         m_busy = 0; m_resp = 0; m_ptr = 0; m_wait = 0;
         m_a1 = '0; m_a2 = '0; m_act = '0;
         exp_q.delete(); id_q.delete();
      end else begin
         e_r0 = !m_busy && !m_resp && bus.req0_valid_i && (!m_ptr || !bus.req1_valid_i);
         e_r1 = !m_busy && !m_resp && bus.req1_valid_i && ( m_ptr || !bus.req0_valid_i);
         chk("ready0", 64'(bus.req0_ready_o), 64'(e_r0));
         chk("ready1", 64'(bus.req1_ready_o), 64'(e_r1));
         chk("rsp_valid", 64'(bus.rsp_valid_o), 64'(m_resp));
         chk("alu_d1", 64'(bus.alu_data1_o), 64'(m_a1));
         chk("alu_d2", 64'(bus.alu_data2_o), 64'(m_a2));
         chk("alu_act", 64'(bus.alu_action_o), 64'(m_act));
         if (m_resp) begin
            chk("rsp_result", 64'(bus.rsp_result_o), 64'(exp_q[0]));
            chk("rsp_id", 64'(bus.rsp_id_o), 64'(id_q[0]));
         end
         if (bus.req0_ready_o && bus.req0_valid_i) dut_grants.push_back(0);
         else if (bus.req1_ready_o && bus.req1_valid_i) dut_grants.push_back(1);

         if (m_resp) begin
            if (bus.rsp_ready_i) begin
               m_resp = 0;
               m_ptr  = !id_q[0];
               void'(exp_q.pop_front());
               void'(id_q.pop_front());
            end
         end else if (m_busy) begin
            m_wait--;
            if (m_wait == 0) begin
               m_busy = 0;
               m_resp = 1;
            end
         end else if (e_r0 || e_r1) begin
            m_a1  = e_r1 ? bus.req1_data1_i  : bus.req0_data1_i;
            m_a2  = e_r1 ? bus.req1_data2_i  : bus.req0_data2_i;
            m_act = e_r1 ? bus.req1_action_i : bus.req0_action_i;
            exp_q.push_back(golden(m_a1, m_a2, m_act));
            id_q.push_back(e_r1);
            m_wait = (m_act == A_MUL) ? 1 + MUL_LAT : 2;
            m_busy = 1;
            acc_flag[e_r1] = 1;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic set_req(input bit id, input bit v, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [2:0] act);
      if (id == 0) begin
         bus.req0_valid_i = v; bus.req0_data1_i = a; bus.req0_data2_i = b; bus.req0_action_i = act;
      end else begin
         bus.req1_valid_i = v; bus.req1_data1_i = a; bus.req1_data2_i = b; bus.req1_action_i = act;
      end
   endtask

   task automatic issue(input bit id, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2:0] act);
      bit ok = 0;
      acc_flag[id] = 0;
      set_req(id, 1, a, b, act);
      for (int k = 0; k < 40; k++) begin
         @(posedge clk_i); #1;
         if (acc_flag[id]) begin
            ok = 1;
            break;
         end
      end
      n_chk++;
      assert (ok) else begin
         n_fail++;
         $error("FAIL accept_timeout: requester %0d not accepted", id);
      end
      set_req(id, 0, a, b, act);
   endtask

   // Rising edges from the call until rsp_valid_o is seen high.
   task automatic wait_rsp(input string tag, output int lat);
      lat = 0;
      for (int k = 1; k <= 30; k++) begin
         @(posedge clk_i); #1;
         if (bus.rsp_valid_o) begin
            lat = k;
            break;
         end
      end
      n_chk++;
      assert (lat != 0) else begin
         n_fail++;
         $error("FAIL %s_timeout: no response observed", tag);
      end
   endtask

   task automatic wait_grants(input int n);
      int base = dut_grants.size();
      bit ok = 0;
      for (int k = 0; k < 100; k++) begin
         @(posedge clk_i); #1;
         if (dut_grants.size() >= base + n) begin
            ok = 1;
            break;
         end
      end
      n_chk++;
      assert (ok) else begin
         n_fail++;
         $error("FAIL grant_timeout: %0d of %0d grants seen", dut_grants.size() - base, n);
      end
   endtask

   task automatic drain();
      bit ok = 0;
      bus.rsp_ready_i = 1;
      for (int k = 0; k < 60; k++) begin
         @(posedge clk_i); #1;
         if (!m_busy && !m_resp) begin
            ok = 1;
            break;
         end
      end
      n_chk++;
      assert (ok) else begin
         n_fail++;
         $error("FAIL drain_timeout: operation still pending");
      end
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      int lat;
      int g;
      logic [W-1:0] held_res;

      set_req(0, 1, 32'd11, 32'd22, A_ADD);
      set_req(1, 1, 32'd33, 32'd44, A_OR);
      bus.rsp_ready_i = 1;

      // Reset held with both requesters valid
      #2 check_zero("reset_t0");
      repeat (3) @(posedge clk_i);
      #1;
      set_req(0, 0, '0, '0, A_AND);
      set_req(1, 0, '0, '0, A_AND);
      rst_i = 1;
      repeat (2) @(posedge clk_i);
      #1;

      // Single ADD from requester 0
      issue(0, 32'd5, 32'd7, A_ADD);
      wait_rsp("add", lat);
      chk("add_latency", 64'(lat), 64'd2);
      chk("add_result", 64'(bus.rsp_result_o), 64'd12);
      chk("add_id", 64'(bus.rsp_id_o), 64'd0);
      drain();

      // MUL from requester 1
      issue(1, 32'd6, 32'd7, A_MUL);
      wait_rsp("mul", lat);
      chk("mul_latency", 64'(lat), 64'(MUL_LAT + 1));
      chk("mul_result", 64'(bus.rsp_result_o), 64'd42);
      chk("mul_id", 64'(bus.rsp_id_o), 64'd1);
      drain();

      // Contention: both requesters valid continuously
      g = dut_grants.size();
      set_req(0, 1, 32'd9, 32'd4, A_SUB);
      set_req(1, 1, 32'h0000_00F0, 32'h0000_000F, A_OR);
      wait_grants(4);
      chk("cont_grant0", 64'(dut_grants[g]), 64'd0);
      chk("cont_grant1", 64'(dut_grants[g+1]), 64'd1);
      chk("cont_grant2", 64'(dut_grants[g+2]), 64'd0);
      chk("cont_grant3", 64'(dut_grants[g+3]), 64'd1);
      set_req(0, 0, '0, '0, A_AND);
      set_req(1, 0, '0, '0, A_AND);
      drain();

      // Backpressure in RESP with both requesters pushing
      bus.rsp_ready_i = 0;
      issue(0, 32'd9, 32'd4, A_SUB);
      set_req(0, 1, 32'd1, 32'd2, A_ADD);
      set_req(1, 1, 32'h0000_00F0, 32'h0000_000F, A_OR);
      wait_rsp("bp", lat);
      held_res = bus.rsp_result_o;
      chk("bp_result", 64'(held_res), 64'd5);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk_i); #1;
         chk("bp_hold_valid", 64'(bus.rsp_valid_o), 64'd1);
         chk("bp_hold_result", 64'(bus.rsp_result_o), 64'd5);
         chk("bp_hold_id", 64'(bus.rsp_id_o), 64'd0);
         chk("bp_ready0_low", 64'(bus.req0_ready_o), 64'd0);
         chk("bp_ready1_low", 64'(bus.req1_ready_o), 64'd0);
      end
      g = dut_grants.size();
      bus.rsp_ready_i = 1;
      @(posedge clk_i); #1;
      chk("bp_released", 64'(bus.rsp_valid_o), 64'd0);
      wait_grants(1);
      chk("bp_next_grant", 64'(dut_grants[g]), 64'd1);
      set_req(0, 0, '0, '0, A_AND);
      set_req(1, 0, '0, '0, A_AND);
      drain();

      // Reset in the middle of a MUL; pointer favours requester 1 beforehand
      issue(0, 32'd3, 32'd3, A_AND);
      drain();
      issue(1, 32'd3, 32'd5, A_MUL);
      @(posedge clk_i); #1;
      rst_i = 0;
      #1 check_zero("mid_reset");
      repeat (2) @(posedge clk_i);
      #1 rst_i = 1;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk_i); #1;
         chk("no_stale_rsp", 64'(bus.rsp_valid_o), 64'd0);
      end
      g = dut_grants.size();
      set_req(0, 1, 32'd2, 32'd3, A_ADD);
      set_req(1, 1, 32'd4, 32'd5, A_ADD);
      wait_grants(1);
      chk("post_reset_grant", 64'(dut_grants[g]), 64'd0);
      set_req(0, 0, '0, '0, A_AND);
      set_req(1, 0, '0, '0, A_AND);
      drain();

      // Illegal action forwarded with non-MUL timing
      illegal_val = 32'hFFFF_FFFF;
      issue(1, 32'd1, 32'd2, A_ILL);
      wait_rsp("ill", lat);
      chk("ill_latency", 64'(lat), 64'd2);
      chk("ill_result", 64'(bus.rsp_result_o), 64'hFFFF_FFFF);
      chk("ill_id", 64'(bus.rsp_id_o), 64'd1);
      drain();

      // Randomized traffic; payload held while a request waits
      illegal_val = $urandom;
      acc_flag[0] = 1;
      acc_flag[1] = 1;
      for (int c = 0; c < 400; c++) begin
         for (int r = 0; r < 2; r++) begin
            bit cur_v = (r == 0) ? bus.req0_valid_i : bus.req1_valid_i;
            if (!cur_v || acc_flag[r]) begin
               acc_flag[r] = 0;
               set_req(r[0], 1'($urandom_range(0, 1)), $urandom, $urandom,
                       3'($urandom_range(0, 7)));
            end
         end
         bus.rsp_ready_i = ($urandom_range(0, 3) != 0);
         @(posedge clk_i); #1;
      end
      set_req(0, 0, '0, '0, A_AND);
      set_req(1, 0, '0, '0, A_AND);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
